// File: rtl/washer_panel_ctrl.sv
// Washing-machine front-panel input conditioner.
//
// Synchronises and debounces the raw panel buttons and the door/soap switches,
// holds the power state, cycles and latches the program selection, issues a
// one-cycle start request to the downstream controller and freezes the panel
// while a program runs, releasing it on program_done.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous reset, active low
//   btn_power_raw     raw power button (1 = pressed)
//   btn_start_raw     raw start button (1 = pressed)
//   btn_prog_raw      raw next-program button (1 = pressed)
//   door_sw_raw       raw door switch (1 = closed)
//   soap_sw_raw       raw soap sensor (1 = soap present)
//   program_done      controller has finished the program
//   power             power level to controller
//   start             one-cycle start request
//   program_selection latched program code, 0..NUM_PROGRAMS-1
//   doorclosed        debounced door level
//   soap              debounced soap level
//   door_warning      start was pressed with the door open
//   panel_state       current state code (0 off, 1 ready, 2 start, 3 running)
module washer_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NUM_PROGRAMS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power_raw,
  input  logic       btn_start_raw,
  input  logic       btn_prog_raw,
  input  logic       door_sw_raw,
  input  logic       soap_sw_raw,
  input  logic       program_done,
  output logic       power,
  output logic       start,
  output logic [2:0] program_selection,
  output logic       doorclosed,
  output logic       soap,
  output logic       door_warning,
  output logic [1:0] panel_state
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int          NumIn = 5;
  // Counter value at which one more mismatching sample completes the debounce.
  localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      ProgLast = 3'(NUM_PROGRAMS - 1);

  localparam int IdxPower = 0;
  localparam int IdxStart = 1;
  localparam int IdxProg  = 2;
  localparam int IdxDoor  = 3;
  localparam int IdxSoap  = 4;

  typedef enum logic [1:0] {
    StOff     = 2'd0,
    StReady   = 2'd1,
    StStart   = 2'd2,
    StRunning = 2'd3
  } state_e;

  logic [NumIn-1:0] w_raw;
  logic [NumIn-1:0] r_sync1, r_sync2;
  logic [NumIn-1:0] r_deb, w_deb_d;
  logic [CntW-1:0]  r_cnt [NumIn];
  logic [CntW-1:0]  w_cnt_d [NumIn];
  logic [2:0]       r_btn_q;
  logic [2:0]       w_press;

  state_e     r_state, w_state_d;
  logic [2:0] r_sel, w_sel_d;
  logic       r_warn, w_warn_d;
  logic       r_start;

  assign w_raw = {soap_sw_raw, door_sw_raw, btn_prog_raw, btn_start_raw, btn_power_raw};

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronised samples that disagree with the current level.
  always_comb begin
    w_deb_d = r_deb;
    for (int i = 0; i < NumIn; i++) begin
      w_cnt_d[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_cnt[i] == CntLast) begin
          w_deb_d[i] = r_sync2[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_btn_q <= '0;
      for (int i = 0; i < NumIn; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb   <= w_deb_d;
      r_btn_q <= r_deb[IdxProg:IdxPower];
      for (int i = 0; i < NumIn; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  // One event per debounced rising edge of each button.
  assign w_press = r_deb[IdxProg:IdxPower] & ~r_btn_q;

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_warn_d  = r_warn;
    unique case (r_state)
      StOff: begin
        if (w_press[IdxPower]) w_state_d = StReady;
      end
      StReady: begin
        // Priority: power over start over program.
        if (w_press[IdxPower]) begin
          w_state_d = StOff;
        end else if (w_press[IdxStart]) begin
          if (r_deb[IdxDoor]) begin
            w_state_d = StStart;
          end else begin
            w_warn_d = 1'b1;
          end
        end else if (w_press[IdxProg]) begin
          w_sel_d = (r_sel == ProgLast) ? 3'd0 : r_sel + 3'd1;
        end
      end
      StStart: begin
        w_state_d = StRunning;
      end
      StRunning: begin
        // Presses are single-cycle events, so anything coinciding with
        // program_done is simply dropped.
        if (program_done) w_state_d = StReady;
      end
      default: begin
        w_state_d = StOff;
      end
    endcase
    if (r_deb[IdxDoor] || (w_state_d == StOff)) w_warn_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StOff;
      r_sel   <= '0;
      r_warn  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_warn  <= w_warn_d;
      r_start <= (w_state_d == StStart);
    end
  end

  assign power             = (r_state != StOff);
  assign start             = r_start;
  assign program_selection = r_sel;
  assign doorclosed        = r_deb[IdxDoor];
  assign soap              = r_deb[IdxSoap];
  assign door_warning      = r_warn;
  assign panel_state       = r_state;

endmodule
